// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad matrix emulator:
// sequence states, key-to-matrix position table and a ms-to-cycles helper.
package keypad_pkg;

  localparam int unsigned LFSR_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    B_PRESS = 3'd1,
    HOLD    = 3'd2,
    B_REL   = 3'd3,
    GAP     = 3'd4
  } state_t;

  // Entry k holds {row[1:0], col[1:0]} of hex key k.
  // Layout: r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: 0 F E D.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'hC, 4'h0, 4'h1, 4'h2,   // 0 1 2 3
    4'h4, 4'h5, 4'h6, 4'h8,   // 4 5 6 7
    4'h9, 4'hA, 4'h3, 4'h7,   // 8 9 A B
    4'hB, 4'hF, 4'hE, 4'hD    // C D E F
  };

  // Computed in 64 bits: ms * CLK_FREQ overflows 32 bits at realistic clock rates.
  function automatic longint unsigned ms_to_cycles(input longint unsigned ms,
                                                   input longint unsigned freq);
    return (ms * freq) / 64'd1000;
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies contact-bounce bits;
// advances only when step is high.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic bit0
);

  logic [LFSR_W-1:0] lfsr;
  logic              feedback;

  assign feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign bit0     = lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {feedback, lfsr[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 keypad matrix model: accepts key presses over valid/ready, closes the
// matching contact with LFSR bounce at both edges, and answers column strobes on rows.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned HOLD_MS     = 50,
  parameter int unsigned BOUNCE_MS   = 2,
  parameter int unsigned GAP_MS      = 10,
  parameter int unsigned BOUNCE_STEP = 1250,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       key_down,
  output logic       busy
);

  localparam int unsigned B_CYC   = 32'(ms_to_cycles(BOUNCE_MS, CLK_FREQ));
  localparam int unsigned H_CYC   = 32'(ms_to_cycles(HOLD_MS, CLK_FREQ));
  localparam int unsigned G_CYC   = 32'(ms_to_cycles(GAP_MS, CLK_FREQ));
  localparam int unsigned MAX_BH  = (B_CYC > H_CYC) ? B_CYC : H_CYC;
  localparam int unsigned MAX_LEN = (MAX_BH > G_CYC) ? MAX_BH : G_CYC;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned STEP_W  = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;

  localparam logic [CNT_W-1:0]  B_LOAD    = CNT_W'(B_CYC - 32'd1);
  localparam logic [CNT_W-1:0]  H_LOAD    = CNT_W'(H_CYC - 32'd1);
  localparam logic [CNT_W-1:0]  G_LOAD    = CNT_W'(G_CYC - 32'd1);
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(BOUNCE_STEP - 32'd1);

  function automatic logic [CNT_W-1:0] phase_load(input state_t s);
    case (s)
      B_PRESS, B_REL: return B_LOAD;
      HOLD:           return H_LOAD;
      GAP:            return G_LOAD;
      default:        return '0;
    endcase
  endfunction

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
  logic                contact, contact_nxt;
  logic [1:0]          row_sel, col_sel;
  logic [3:0]          sync [SYNC_STAGES];
  logic [3:0]          col_sync;
  logic [3:0]          row_nxt;
  logic                accept, bounce, step, lfsr_bit, cnt_done;

  assign accept   = key_valid && key_ready && (state == IDLE);
  assign bounce   = (state == B_PRESS) || (state == B_REL);
  assign step     = bounce && (step_cnt == '0);
  assign cnt_done = (cnt == '0);
  assign col_sync = sync[SYNC_STAGES-1];

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .bit0 (lfsr_bit)
  );

  // Column strobe synchronizer; idles at the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync[i] <= 4'hF;
    end else begin
      sync[0] <= col_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync[i] <= sync[i-1];
    end
  end

  // Zero-length bounce phases are skipped, so each exit picks the next non-empty phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (B_CYC != 32'd0) ? B_PRESS : HOLD;
        else        state_nxt = IDLE;
      end
      B_PRESS: begin
        if (cnt_done) state_nxt = HOLD;
        else          state_nxt = B_PRESS;
      end
      HOLD: begin
        if (!cnt_done)              state_nxt = HOLD;
        else if (B_CYC != 32'd0)    state_nxt = B_REL;
        else if (G_CYC != 32'd0)    state_nxt = GAP;
        else                        state_nxt = IDLE;
      end
      B_REL: begin
        if (!cnt_done)              state_nxt = B_REL;
        else if (G_CYC != 32'd0)    state_nxt = GAP;
        else                        state_nxt = IDLE;
      end
      GAP: begin
        if (cnt_done) state_nxt = IDLE;
        else          state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase

    cnt_nxt = cnt;
    if (state_nxt != state)  cnt_nxt = phase_load(state_nxt);
    else if (!cnt_done)      cnt_nxt = cnt - CNT_W'(1'b1);
    else                     cnt_nxt = cnt;

    step_cnt_nxt = step_cnt;
    if (state_nxt != state)  step_cnt_nxt = STEP_LOAD;
    else if (step)           step_cnt_nxt = STEP_LOAD;
    else if (bounce)         step_cnt_nxt = step_cnt - STEP_W'(1'b1);
    else                     step_cnt_nxt = step_cnt;

    // Phase exits force the contact; inside a bounce phase it follows the LFSR.
    contact_nxt = contact;
    if (state_nxt == HOLD)                          contact_nxt = 1'b1;
    else if (state_nxt == GAP || state_nxt == IDLE) contact_nxt = 1'b0;
    else if (step)                                  contact_nxt = lfsr_bit;
    else                                            contact_nxt = contact;

    row_nxt = 4'hF;
    if (contact && !col_sync[col_sel]) row_nxt[row_sel] = 1'b0;
    else                               row_nxt = 4'hF;
  end

  // Sequence state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      step_cnt  <= '0;
      contact   <= 1'b0;
      row_sel   <= 2'd0;
      col_sel   <= 2'd0;
      row_out   <= 4'hF;
      key_ready <= 1'b1;
      key_down  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      step_cnt  <= step_cnt_nxt;
      contact   <= contact_nxt;
      row_out   <= row_nxt;
      key_ready <= (state == IDLE) && !accept;
      key_down  <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
      if (accept) {row_sel, col_sel} <= KEY_MAP[key_code];
    end
  end

endmodule
